// File: rtl/vector_register_bank_if.sv
// Issue/writeback/read port bundle for vector_register_bank.
// The master side is the pipeline; the slave side is the register bank.
interface vector_register_bank_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
);
  logic                    we3;
  logic [AW-1:0]           a3;
  logic [LANES-1:0]        mask3;
  logic [LANES*LANE_W-1:0] wd3;
  logic [AW-1:0]           a1;
  logic [AW-1:0]           a2;
  logic [LANES*LANE_W-1:0] rd1;
  logic [LANES*LANE_W-1:0] rd2;
  logic                    iss;
  logic [AW-1:0]           iss_a;
  logic                    iss_ack;
  logic                    busy1;
  logic                    busy2;

  modport master (
    output we3, a3, mask3, wd3, a1, a2, iss, iss_a,
    input  rd1, rd2, iss_ack, busy1, busy2
  );

  modport slave (
    input  we3, a3, mask3, wd3, a1, a2, iss, iss_a,
    output rd1, rd2, iss_ack, busy1, busy2
  );
endinterface

// File: rtl/vector_register_bank.sv
// Vector register bank: DEPTH x LANES x LANE_W, two forwarding read ports,
// one lane-masked write port and a per-register pending-write scoreboard.
module vector_register_bank #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input logic                   clk,
  input logic                   rst,
  vector_register_bank_if.slave bus
);

  localparam int unsigned VW = LANES * LANE_W;

  logic [VW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             iss_ack;

  // Register file storage; reset takes priority so X inputs during reset are harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else if (bus.we3) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.mask3[i]) begin
          mem_q[bus.a3][i*LANE_W +: LANE_W] <= bus.wd3[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // A same-cycle writeback frees the register, so a WAW issue to it may proceed.
  assign iss_ack = bus.iss & ~rst &
                   (~busy_q[bus.iss_a] | (bus.we3 & (bus.a3 == bus.iss_a)));

  // Clear first, then set, so an issue to the register being written back wins.
  always_comb begin
    busy_d = busy_q;
    if (bus.we3) begin
      busy_d[bus.a3] = 1'b0;
    end
    if (iss_ack) begin
      busy_d[bus.iss_a] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    bus.rd1 = mem_q[bus.a1];
    bus.rd2 = mem_q[bus.a2];
    for (int i = 0; i < LANES; i++) begin
      if (bus.we3 && bus.mask3[i]) begin
        if (bus.a1 == bus.a3) begin
          bus.rd1[i*LANE_W +: LANE_W] = bus.wd3[i*LANE_W +: LANE_W];
        end
        if (bus.a2 == bus.a3) begin
          bus.rd2[i*LANE_W +: LANE_W] = bus.wd3[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign bus.iss_ack = iss_ack;
  assign bus.busy1   = busy_q[bus.a1] & ~(bus.we3 & (bus.a3 == bus.a1));
  assign bus.busy2   = busy_q[bus.a2] & ~(bus.we3 & (bus.a3 == bus.a2));

endmodule

// File: tb/tb_vector_register_bank.sv
// Directed self-checking bench for vector_register_bank: default 4x32x16 instance
// plus a 1x8x4 instance for the reduced-parameter case.
module tb_vector_register_bank;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  vector_register_bank_if #(.LANES(4), .LANE_W(32), .DEPTH(16)) bus_a ();
  vector_register_bank_if #(.LANES(1), .LANE_W(8),  .DEPTH(4))  bus_b ();

  vector_register_bank #(.LANES(4), .LANE_W(32), .DEPTH(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  vector_register_bank #(.LANES(1), .LANE_W(8), .DEPTH(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] lanes(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus_a.we3 = 1'b0; bus_a.a3 = '0; bus_a.mask3 = '0; bus_a.wd3 = '0;
    bus_a.a1 = '0; bus_a.a2 = '0; bus_a.iss = 1'b1; bus_a.iss_a = 4'd5;
    bus_b.we3 = 1'b0; bus_b.a3 = '0; bus_b.mask3 = '0; bus_b.wd3 = '0;
    bus_b.a1 = '0; bus_b.a2 = '0; bus_b.iss = 1'b0; bus_b.iss_a = '0;
    #1;
    check("ack_blocked_in_reset", bus_a.iss_ack, 0);
    tick();
    rst = 1'b0;
    #1;
    check("ack_after_reset", bus_a.iss_ack, 1);
    bus_a.iss = 1'b0;
    bus_a.a1 = 4'd0; bus_a.a2 = 4'd15;
    #1;
    check("reset_rd1", bus_a.rd1, 0);
    check("reset_rd2", bus_a.rd2, 0);
    check("reset_busy1", bus_a.busy1, 0);
    check("reset_busy2", bus_a.busy2, 0);

    // Fill registers 1..15 with distinct per-lane values.
    for (int i = 1; i < 16; i++) begin
      bus_a.we3 = 1'b1; bus_a.mask3 = 4'hF; bus_a.a3 = 4'(i);
      bus_a.wd3 = lanes(i, i + 16, i + 32, i + 48);
      tick();
    end
    bus_a.we3 = 1'b0;
    for (int i = 1; i < 16; i++) begin
      bus_a.a1 = 4'(i); bus_a.a2 = 4'(i);
      #1;
      check($sformatf("fill_rd1_r%0d", i), bus_a.rd1, lanes(i, i + 16, i + 32, i + 48));
      check($sformatf("fill_rd2_r%0d", i), bus_a.rd2, lanes(i, i + 16, i + 32, i + 48));
    end
    bus_a.a1 = 4'd0;
    #1;
    check("r0_still_zero", bus_a.rd1, 0);

    // Partial-mask write to reg5.
    bus_a.we3 = 1'b1; bus_a.a3 = 4'd5; bus_a.mask3 = 4'b0101; bus_a.wd3 = {128{1'b1}};
    tick();
    bus_a.we3 = 1'b0; bus_a.a1 = 4'd5;
    #1;
    check("partial_mask_r5", bus_a.rd1, lanes(32'hFFFF_FFFF, 21, 32'hFFFF_FFFF, 53));

    // Forwarding of a single lane; unmasked WD3 lanes carry junk that must not leak.
    bus_a.we3 = 1'b1; bus_a.a3 = 4'd7; bus_a.mask3 = 4'b0010;
    bus_a.wd3 = lanes(32'h1111, 32'hABCD, 32'h2222, 32'h3333);
    bus_a.a1 = 4'd7; bus_a.a2 = 4'd6;
    #1;
    check("fwd_rd1", bus_a.rd1, lanes(7, 32'hABCD, 39, 55));
    check("fwd_rd2_other", bus_a.rd2, lanes(6, 22, 38, 54));
    bus_a.a2 = 4'd7;
    #1;
    check("fwd_rd2_same", bus_a.rd2, lanes(7, 32'hABCD, 39, 55));
    tick();
    bus_a.we3 = 1'b0;
    #1;
    check("fwd_committed", bus_a.rd1, lanes(7, 32'hABCD, 39, 55));

    // Register 0 is an ordinary register.
    bus_a.we3 = 1'b1; bus_a.a3 = 4'd0; bus_a.mask3 = 4'hF; bus_a.wd3 = lanes(10, 11, 12, 13);
    tick();
    bus_a.we3 = 1'b0; bus_a.a1 = 4'd0;
    #1;
    check("r0_write", bus_a.rd1, lanes(10, 11, 12, 13));

    // Scoreboard: issue, WAW reject, same-cycle writeback+issue.
    bus_a.iss = 1'b1; bus_a.iss_a = 4'd3;
    #1;
    check("iss3_ack", bus_a.iss_ack, 1);
    tick();
    bus_a.iss = 1'b0; bus_a.a1 = 4'd3; bus_a.a2 = 4'd4;
    #1;
    check("busy3_set", bus_a.busy1, 1);
    check("busy4_clear", bus_a.busy2, 0);
    bus_a.iss = 1'b1;
    #1;
    check("iss3_waw_reject", bus_a.iss_ack, 0);
    tick();
    bus_a.we3 = 1'b1; bus_a.a3 = 4'd3; bus_a.mask3 = 4'b0000; bus_a.wd3 = {128{1'b1}};
    #1;
    check("iss3_with_wb_ack", bus_a.iss_ack, 1);
    check("busy3_hidden_by_wb", bus_a.busy1, 0);
    check("mask0_no_fwd", bus_a.rd1, lanes(3, 19, 35, 51));
    tick();
    bus_a.we3 = 1'b0; bus_a.iss = 1'b0;
    #1;
    check("busy3_issue_wins", bus_a.busy1, 1);
    check("mask0_no_write", bus_a.rd1, lanes(3, 19, 35, 51));
    bus_a.we3 = 1'b1; bus_a.mask3 = 4'b0000;
    tick();
    bus_a.we3 = 1'b0;
    #1;
    check("busy3_cleared_by_wb", bus_a.busy1, 0);
    bus_a.iss = 1'b1; bus_a.iss_a = 4'd15;
    tick();
    bus_a.iss = 1'b0; bus_a.a2 = 4'd15;
    #1;
    check("busy15_set", bus_a.busy2, 1);

    // Reset mid-operation with a write and an issue pending at the reset edge.
    bus_a.iss = 1'b1; bus_a.iss_a = 4'd3;
    tick();
    bus_a.iss_a = 4'd9;
    tick();
    bus_a.iss = 1'b0; bus_a.a1 = 4'd3; bus_a.a2 = 4'd9;
    #1;
    check("pre_rst_busy3", bus_a.busy1, 1);
    check("pre_rst_busy9", bus_a.busy2, 1);
    rst = 1'b1;
    bus_a.we3 = 1'b1; bus_a.a3 = 4'd2; bus_a.mask3 = 4'hF; bus_a.wd3 = {128{1'b1}};
    bus_a.iss = 1'b1; bus_a.iss_a = 4'd4;
    tick();
    rst = 1'b0; bus_a.we3 = 1'b0; bus_a.iss = 1'b0;
    #1;
    check("rst_busy3", bus_a.busy1, 0);
    check("rst_busy9", bus_a.busy2, 0);
    check("rst_rd3", bus_a.rd1, 0);
    check("rst_rd9", bus_a.rd2, 0);
    bus_a.a1 = 4'd2; bus_a.a2 = 4'd4;
    #1;
    check("rst_no_write_r2", bus_a.rd1, 0);
    check("rst_no_issue_r4", bus_a.busy2, 0);
    bus_a.a2 = 4'd15;
    #1;
    check("rst_busy15", bus_a.busy2, 0);

    // Reduced-parameter instance.
    bus_b.we3 = 1'b1; bus_b.a3 = 2'd3; bus_b.mask3 = 1'b1; bus_b.wd3 = 8'h5A;
    tick();
    bus_b.we3 = 1'b0; bus_b.a1 = 2'd3;
    #1;
    check("small_rd_r3", bus_b.rd1, 8'h5A);
    bus_b.a1 = 2'd0;
    #1;
    check("small_rd_r0", bus_b.rd1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vector_register_bank.md
Name: vector_register_bank

Overview:
- Parametrised successor to the scalar 16x32 register bank of the vector ASIP.
- Holds DEPTH vector registers of LANES elements, each LANE_W bits wide.
- Two combinational read ports with same-cycle write forwarding, and one write port with a per-lane write mask.
- Adds a busy scoreboard so the issue stage can detect pending writebacks: issue marks a destination busy, and writeback clears it.

Parameters:
- LANES, 4, number of vector elements per register
- LANE_W, 32, bits per element
- DEPTH, 16, number of vector registers (power of two, >=2)
- AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- WE3  in  1  write enable, writeback port
- A3  in  AW  write address
- MASK3  in  LANES  per-lane write mask; bit i enables lane i
- WD3  in  LANES*LANE_W  write data; lane i = bits [i*LANE_W +: LANE_W]
- A1  in  AW  read address, port 1
- A2  in  AW  read address, port 2
- RD1  out  LANES*LANE_W  read data, port 1
- RD2  out  LANES*LANE_W  read data, port 2
- ISS  in  1  issue request: destination ISS_A will be written later
- ISS_A  in  AW  destination address of issued instruction
- ISS_ACK  out  1  issue accepted this cycle
- BUSY1  out  1  register A1 has a pending write
- BUSY2  out  1  register A2 has a pending write

Behaviour:
- Reset (RST=1 at rising edge):
  - all DEPTH registers, all lanes := 0
  - all busy bits := 0
  - write and issue inputs ignored that cycle
  - reset mid-operation discards pending busy state; no partial writes.
- After reset, with no write active: RD1=RD2=0 for any address, BUSY1=BUSY2=0, ISS_ACK=ISS.
- Write, at edge with WE3=1 and RST=0:
  - for each lane i with MASK3[i]=1: reg[A3].lane[i] := WD3 lane i
  - lanes with MASK3[i]=0 are unchanged
  - MASK3=0 with WE3=1 writes no data but still clears busy[A3].
- Read: combinational, zero-cycle latency.
- Forwarding: RDn lane i = WD3 lane i when WE3=1, An==A3 and MASK3[i]=1; otherwise the stored lane. Port 1 and port 2 forward independently; both may forward the same write.
- Busy scoreboard (one bit per register):
  - ISS_ACK = ISS & ~RST & (~busy[ISS_A] | (WE3 & A3==ISS_A)). An issue to a busy register is rejected (WAW stall) unless that register is being written back in the same cycle.
  - At edge, when ISS_ACK=1: busy[ISS_A] := 1.
  - At edge, when WE3=1: busy[A3] := 0.
  - If issue and writeback target the same register in the same cycle, issue wins: busy stays 1.
  - Writeback to a non-busy register is legal; busy stays 0.
  - BUSYn = busy[An] & ~(WE3 & A3==An). The register being written this cycle reads as not busy, consistent with forwarding.
- Address wrap: none. All AW-bit addresses are valid, including register 0 and register DEPTH-1; neither is special.
- No X on outputs after the first reset; X on inputs while RST=1 must not corrupt state.

Test Plan:
- Reset, then loop i=1..15: WE3=1, MASK3=4'hF, A3=i, WD3 lanes = {i,i+16,i+32,i+48}. Then read A1=A2=i -> RD1=RD2 with lanes {i,i+16,i+32,i+48}; A1=0 -> RD1=0.
- Partial mask: reg5 = {5,21,37,53}; write A3=5, MASK3=4'b0101, WD3 lanes = FFFF_FFFF -> reg5 = {FFFF_FFFF,21,FFFF_FFFF,53}.
- Forwarding: same cycle WE3=1, A3=A1=7, MASK3=4'b0010, lane1=32'hABCD -> RD1 lane1=ABCD before the edge, other lanes old values; RD2 with A2=6 unaffected.
- Scoreboard:
  - ISS=1, ISS_A=3 -> ISS_ACK=1; next cycle A1=3 -> BUSY1=1.
  - ISS again to 3 -> ISS_ACK=0.
  - WE3=1, A3=3 with ISS=1, ISS_A=3 in the same cycle -> ISS_ACK=1, BUSY1=0 that cycle, BUSY1=1 after the edge.
- Reset mid-operation: registers written and busy[3], busy[9] set; assert RST one cycle with WE3=1, ISS=1 -> all RDn=0, BUSY1=BUSY2=0, no write or issue took effect.
- Parameter sweep: LANES=1, LANE_W=8, DEPTH=4 -> write A3=3, WD3=8'h5A, then read A1=3 -> RD1=8'h5A; A1=0 -> RD1=0.
